decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the 16-bit pipeline, directly downstream of instruction fetch.
//  Consumes InstrD/PCPlus2D, decodes opcode, reads the 16x16 register file, sign-extends immediates.
//  Registers all data and control into the ID/EX pipeline register for execute.
//  Hosts the register-file write port driven from writeback.
// PARAMETERS
//  NREGS  16  architectural registers; r0 hardwired to zero
//  XLEN   16  data/instruction width
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   synchronous, active-high reset
//  InstrD       in   16  instruction from IF/ID
//  PCPlus2D     in   16  PC+1 (word-addressed) from IF/ID
//  FlushE       in   1   hazard unit: load bubble into ID/EX
//  RegWriteW    in   1   writeback write enable
//  RdW          in   4   writeback destination
//  ResultW      in   16  writeback data
//  Rs1D, Rs2D   out  4   combinational source indices, to hazard unit
//  RD1E, RD2E   out  16  registered operands
//  ImmExtE      out  16  registered extended immediate
//  RdE,Rs1E,Rs2E out 4   registered register indices (forwarding)
//  PCPlus2E     out  16  registered PC+1; execute forms target = PCPlus2E + ImmExtE
//  RegWriteE, MemWriteE, ResultSrcE, BranchE, BranchNeE, JumpE, ALUSrcE, HaltE  out 1
//  ALUControlE  out  3   000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLL,110 SRL
// BEHAVIOUR
//  Fields: op=[15:12]. R: rd[11:8] rs1[7:4] rs2[3:0]. I: rd rs1 imm4[3:0].
//   S: rs2(data)[11:8] rs1[7:4] imm4. B: rs1[11:8] rs2[7:4] imm4. J: imm12[11:0]. U: rd imm8[7:0].
//  Opcodes: 0 NOP; 1-7 ADD,SUB,AND,OR,XOR,SLL,SRL (R); 8 ADDI, 9 LDR (I); A STR (S);
//   B BEQ, C BNE (B); D JMP (J); E LUI (U, rs1 forced 0, imm={imm8,8'h00}, ALU ADD); F HALT.
//  imm4/imm12 sign-extended to 16 b; shifts use RD2/imm low 4 bits (execute).
//  Unused source fields drive Rs1D/Rs2D = 0 (no false hazards); non-writing ops: RdE=0, RegWriteE=0.
//  LDR: ResultSrc=1, ALUSrc=1. STR: MemWrite=1, ALUSrc=1. BEQ/BNE: Branch=1, BranchNe=op==C, ALU SUB.
//  Unused NOP/HALT: all controls 0 except HaltE=1 for HALT.
//  Regfile: write on posedge when RegWriteW && RdW!=0; writes to r0 ignored; r0 reads 0.
//  Same-cycle bypass: if RegWriteW && RdW!=0 && RdW==RsxD, RDx reads ResultW (write-before-read).
//  ID/EX latency: 1 cycle; outputs valid the cycle after InstrD presented.
//  Priority per edge: rst > FlushE > normal load. FlushE: every E output <= 0 (NOP bubble).
//  Reset: all E outputs 0, all registers 0; Rs1D/Rs2D follow InstrD combinationally.
//  Reset asserted mid-operation discards the in-flight ID/EX contents same edge.
//  No stall input: IF/ID holds InstrD during stall and hazard unit flushes ID/EX.
// STRUCTURE
//  decode_pkg: opcode_t enum, alu_ctrl_t enum, field slice constants, ctrl_t struct.
//  Sub-module regfile (NREGS x XLEN, 2 read / 1 write, bypass, sync reset).
//  Top: combinational decoder into ctrl_t + immediate mux, then ID/EX register.
// TESTING
//  Reset: rst=1 two cycles -> all E outputs 0, regfile reads 0 for r1..r15.
//  Writeback+read same cycle: RegWriteW=1,RdW=3,ResultW=16'hBEEF, InstrD=16'h1430 (ADD r4,r3,r0)
//   -> next edge RD1E=16'hBEEF, RdE=4, RegWriteE=1, ALUControlE=000.
//  r0 protection: write RdW=0 ResultW=16'h1234, then read r0 -> RD1E=0.
//  Immediates: ADDI 16'h821F -> ImmExtE=16'hFFFF; JMP 16'hD800 -> ImmExtE=16'hF800, JumpE=1, RegWriteE=0;
//   LUI 16'hE5AB -> ImmExtE=16'hAB00, Rs1E=0.
//  Flush: InstrD=STR 16'hA213 with FlushE=1 -> MemWriteE=0, all E outputs 0; next cycle FlushE=0 -> MemWriteE=1, ImmExtE=16'h0003.
//  Branch: BNE 16'hC12E -> BranchE=1, BranchNeE=1, Rs1E=1, Rs2E=2, ImmExtE=16'hFFFE, ALUControlE=001.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode-stage types: opcodes, ALU selects, instruction field slices,
// control bundle and ID/EX register layout.
package decode_pkg;

  localparam int NREGS  = 16;
  localparam int XLEN   = 16;
  localparam int REG_AW = 4;

  // Instruction field slice bounds
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int FA_HI = 11;
  localparam int FA_LO = 8;
  localparam int FB_HI = 7;
  localparam int FB_LO = 4;
  localparam int FC_HI = 3;
  localparam int FC_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LDR  = 4'h9,
    OP_STR  = 4'hA,
    OP_BEQ  = 4'hB,
    OP_BNE  = 4'hC,
    OP_JMP  = 4'hD,
    OP_LUI  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110
  } alu_ctrl_t;

  typedef struct packed {
    logic      reg_write;
    logic      mem_write;
    logic      result_src;
    logic      branch;
    logic      branch_ne;
    logic      jump;
    logic      alu_src;
    logic      halt;
    alu_ctrl_t alu_ctrl;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc_plus2;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    ctrl_t             ctrl;
  } idex_t;

  // ALU operation for the register-register opcodes
  function automatic alu_ctrl_t r_alu(input opcode_t op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SLL:  return ALU_SLL;
      OP_SRL:  return ALU_SRL;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sext4(input logic [3:0] v);
    return {{(XLEN-4){v[3]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// ID/EX pipeline-register bundle handed from decode to execute.
interface decode_stage_if;
  import decode_pkg::*;

  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCPlus2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              ResultSrcE;
  logic              BranchE;
  logic              BranchNeE;
  logic              JumpE;
  logic              ALUSrcE;
  logic              HaltE;
  logic [2:0]        ALUControlE;

  modport master (
    output RD1E, RD2E, ImmExtE, PCPlus2E, RdE, Rs1E, Rs2E,
           RegWriteE, MemWriteE, ResultSrcE, BranchE, BranchNeE,
           JumpE, ALUSrcE, HaltE, ALUControlE
  );

  modport slave (
    input RD1E, RD2E, ImmExtE, PCPlus2E, RdE, Rs1E, Rs2E,
          RegWriteE, MemWriteE, ResultSrcE, BranchE, BranchNeE,
          JumpE, ALUSrcE, HaltE, ALUControlE
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// Register file: NREGS x XLEN, two combinational read ports with
// write-before-read bypass, one write port, r0 hardwired to zero.
module decode_stage_regfile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0]   regs_q [NREGS];
  logic              wr_hit;
  logic [REG_AW-1:0] raddr [2];
  logic [XLEN-1:0]   rdata [2];

  // A write to r0 is never a real write
  assign wr_hit   = we_i && (waddr_i != '0);
  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;
  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

  // Storage update: reset clears every entry, otherwise commit writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      // Read port: r0 forced to zero, in-flight writeback bypassed
      always_comb begin
        rdata[gi] = regs_q[raddr[gi]];
        if (raddr[gi] == '0) begin
          rdata[gi] = '0;
        end else if (wr_hit && (waddr_i == raddr[gi])) begin
          rdata[gi] = wdata_i;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// Decode stage: opcode decode, register read, immediate extension and the
// ID/EX pipeline register feeding execute.
module decode_stage
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCPlus2D,
  input  logic              FlushE,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RdW,
  input  logic [XLEN-1:0]   ResultW,
  output logic [REG_AW-1:0] Rs1D,
  output logic [REG_AW-1:0] Rs2D,
  decode_stage_if.master    ex
);

  opcode_t           op;
  logic [3:0]        f_a;
  logic [3:0]        f_b;
  logic [3:0]        f_c;
  ctrl_t             ctrl_d;
  logic [REG_AW-1:0] rd_d;
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [XLEN-1:0]   imm_d;
  logic [XLEN-1:0]   rd1;
  logic [XLEN-1:0]   rd2;
  idex_t             idex_d;
  idex_t             idex_q;

  assign op  = opcode_t'(InstrD[OP_HI:OP_LO]);
  assign f_a = InstrD[FA_HI:FA_LO];
  assign f_b = InstrD[FB_HI:FB_LO];
  assign f_c = InstrD[FC_HI:FC_LO];

  // Decoder: unused register fields stay 0 so the hazard unit sees no false deps
  always_comb begin
    ctrl_d = '0;
    rd_d   = '0;
    rs1_d  = '0;
    rs2_d  = '0;
    imm_d  = '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = r_alu(op);
        rd_d  = f_a;
        rs1_d = f_b;
        rs2_d = f_c;
      end
      OP_ADDI, OP_LDR: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = (op == OP_LDR);
        rd_d  = f_a;
        rs1_d = f_b;
        imm_d = sext4(f_c);
      end
      OP_STR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        rs2_d = f_a;
        rs1_d = f_b;
        imm_d = sext4(f_c);
      end
      OP_BEQ, OP_BNE: begin
        ctrl_d.branch    = 1'b1;
        ctrl_d.branch_ne = (op == OP_BNE);
        ctrl_d.alu_ctrl  = ALU_SUB;
        rs1_d = f_a;
        rs2_d = f_b;
        imm_d = sext4(f_c);
      end
      OP_JMP: begin
        ctrl_d.jump = 1'b1;
        imm_d = sext12(InstrD[11:0]);
      end
      OP_LUI: begin
        // Executes as r0 + (imm8 << 8)
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        rd_d  = f_a;
        imm_d = {InstrD[7:0], 8'h00};
      end
      OP_HALT: ctrl_d.halt = 1'b1;
      default: ;
    endcase
  end

  assign Rs1D = rs1_d;
  assign Rs2D = rs2_d;

  decode_stage_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (RegWriteW),
    .waddr_i  (RdW),
    .wdata_i  (ResultW),
    .raddr1_i (rs1_d),
    .raddr2_i (rs2_d),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Gather everything execute needs into one ID/EX word
  always_comb begin
    idex_d          = '0;
    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.imm      = imm_d;
    idex_d.pc_plus2 = PCPlus2D;
    idex_d.rd       = rd_d;
    idex_d.rs1      = rs1_d;
    idex_d.rs2      = rs2_d;
    idex_d.ctrl     = ctrl_d;
  end

  // ID/EX register: reset and flush both load an all-zero NOP bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else if (FlushE) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex.RD1E        = idex_q.rd1;
  assign ex.RD2E        = idex_q.rd2;
  assign ex.ImmExtE     = idex_q.imm;
  assign ex.PCPlus2E    = idex_q.pc_plus2;
  assign ex.RdE         = idex_q.rd;
  assign ex.Rs1E        = idex_q.rs1;
  assign ex.Rs2E        = idex_q.rs2;
  assign ex.RegWriteE   = idex_q.ctrl.reg_write;
  assign ex.MemWriteE   = idex_q.ctrl.mem_write;
  assign ex.ResultSrcE  = idex_q.ctrl.result_src;
  assign ex.BranchE     = idex_q.ctrl.branch;
  assign ex.BranchNeE   = idex_q.ctrl.branch_ne;
  assign ex.JumpE       = idex_q.ctrl.jump;
  assign ex.ALUSrcE     = idex_q.ctrl.alu_src;
  assign ex.HaltE       = idex_q.ctrl.halt;
  assign ex.ALUControlE = idex_q.ctrl.alu_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random
// instruction/writeback streams against an instruction-class model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] InstrD;
  logic [15:0] PCPlus2D;
  logic        FlushE;
  logic        RegWriteW;
  logic [3:0]  RdW;
  logic [15:0] ResultW;
  logic [3:0]  Rs1D;
  logic [3:0]  Rs2D;

  decode_stage_if ex_if ();

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .InstrD    (InstrD),
    .PCPlus2D  (PCPlus2D),
    .FlushE    (FlushE),
    .RegWriteW (RegWriteW),
    .RdW       (RdW),
    .ResultW   (ResultW),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .ex        (ex_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model_rf [16];
  logic [86:0] exp_vec;
  int          exp_rs1d, exp_rs2d;
  logic [3:0]  got_rs1d, got_rs2d;

  // Observed E outputs in the same order the model builds them
  function automatic logic [86:0] got_vec();
    return {ex_if.RD1E, ex_if.RD2E, ex_if.ImmExtE, ex_if.RdE, ex_if.Rs1E, ex_if.Rs2E,
            ex_if.PCPlus2E, ex_if.RegWriteE, ex_if.MemWriteE, ex_if.ResultSrcE,
            ex_if.BranchE, ex_if.BranchNeE, ex_if.JumpE, ex_if.ALUSrcE, ex_if.HaltE,
            ex_if.ALUControlE};
  endfunction

  // Instruction-class reference: what execute should see for this instruction
  function automatic logic [86:0] model_expect(input logic [15:0] instr, input logic [15:0] pc,
                                               output int rs1, output int rs2);
    int op, a, b, c, rd, imm, alu, v;
    bit is_r, is_i, is_s, is_b, is_j, is_u;
    op = int'(instr[15:12]);
    a  = int'(instr[11:8]);
    b  = int'(instr[7:4]);
    c  = int'(instr[3:0]);
    is_r = (op >= 1) && (op <= 7);
    is_i = (op == 8) || (op == 9);
    is_s = (op == 10);
    is_b = (op == 11) || (op == 12);
    is_j = (op == 13);
    is_u = (op == 14);
    rd  = (is_r || is_i || is_u) ? a : 0;
    rs1 = (is_r || is_i || is_s) ? b : (is_b ? a : 0);
    rs2 = is_r ? c : (is_s ? a : (is_b ? b : 0));
    imm = 0;
    if (is_i || is_s || is_b) imm = (c >= 8) ? c - 16 : c;
    if (is_j) begin
      v   = int'(instr[11:0]);
      imm = (v >= 2048) ? v - 4096 : v;
    end
    if (is_u) imm = int'(instr[7:0]) * 256;
    alu = is_r ? op - 1 : (is_b ? 1 : 0);
    return {model_rf[rs1], model_rf[rs2], 16'(imm), 4'(rd), 4'(rs1), 4'(rs2), pc,
            1'(is_r || is_i || is_u), 1'(is_s), 1'(op == 9), 1'(is_b), 1'(op == 12),
            1'(is_j), 1'(is_i || is_s || is_u), 1'(op == 15), 3'(alu)};
  endfunction

  // Apply one cycle of inputs, update the model, and land 1 ns after the edge
  task automatic drive_cycle(input logic r, input logic [15:0] instr, input logic [15:0] pc,
                             input logic fl, input logic we, input logic [3:0] rdw,
                             input logic [15:0] res);
    logic [86:0] e;
    rst = r; InstrD = instr; PCPlus2D = pc; FlushE = fl;
    RegWriteW = we; RdW = rdw; ResultW = res;
    #1;
    got_rs1d = Rs1D;
    got_rs2d = Rs2D;
    if (r) begin
      for (int i = 0; i < 16; i++) model_rf[i] = 16'h0;
    end else if (we && rdw != 4'd0) begin
      model_rf[rdw] = res;
    end
    e = model_expect(instr, pc, exp_rs1d, exp_rs2d);
    exp_vec = (r || fl) ? 87'h0 : e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 16'h0000, 16'h0, 0, 0, 4'd0, 16'h0);
    for (int i = 1; i < 16; i++)
      drive_cycle(0, 16'h0000, 16'h0, 0, 1, 4'(i), 16'(i * 16'h1111));
    drive_cycle(0, 16'h1120, 16'h0042, 0, 0, 4'd0, 16'h0);
    drive_cycle(1, 16'h1120, 16'h0043, 0, 1, 4'd5, 16'hAAAA);
    drive_cycle(1, 16'h1120, 16'h0044, 0, 1, 4'd6, 16'h5555);
    n_checks++;
    if (got_vec() !== 87'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", got_vec());
    end
    for (int i = 1; i < 16; i++) begin
      drive_cycle(0, {4'h1, 4'h1, 4'(i), 4'(i)}, 16'h0, 0, 0, 4'd0, 16'h0);
      n_checks++;
      if (ex_if.RD1E !== 16'h0 || ex_if.RD2E !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_reg r%0d: got %h/%h required 0000/0000", i, ex_if.RD1E, ex_if.RD2E);
      end
    end
  endtask

  task automatic test_wb_bypass();
    drive_cycle(0, 16'h1430, 16'h0010, 0, 1, 4'd3, 16'hBEEF);
    n_checks++;
    if (ex_if.RD1E !== 16'hBEEF || ex_if.RdE !== 4'd4 || ex_if.RegWriteE !== 1'b1 ||
        ex_if.ALUControlE !== 3'b000) begin
      n_fail++;
      $display("FAIL wb_bypass: got RD1E=%h RdE=%0d RegWriteE=%b ALU=%b required BEEF 4 1 000",
               ex_if.RD1E, ex_if.RdE, ex_if.RegWriteE, ex_if.ALUControlE);
    end
    drive_cycle(0, 16'h2533, 16'h0011, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.RD1E !== 16'hBEEF || ex_if.RD2E !== 16'hBEEF || ex_if.ALUControlE !== 3'b001) begin
      n_fail++;
      $display("FAIL wb_stored: got %h/%h alu=%b required BEEF/BEEF 001",
               ex_if.RD1E, ex_if.RD2E, ex_if.ALUControlE);
    end
  endtask

  task automatic test_r0();
    drive_cycle(0, 16'h1100, 16'h0020, 0, 1, 4'd0, 16'h1234);
    n_checks++;
    if (ex_if.RD1E !== 16'h0) begin
      n_fail++;
      $display("FAIL r0_bypass: got %h required 0000", ex_if.RD1E);
    end
    drive_cycle(0, 16'h1100, 16'h0021, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.RD1E !== 16'h0 || ex_if.RD2E !== 16'h0) begin
      n_fail++;
      $display("FAIL r0_read: got %h/%h required 0000/0000", ex_if.RD1E, ex_if.RD2E);
    end
  endtask

  task automatic test_immediates();
    drive_cycle(0, 16'h821F, 16'h0030, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.ImmExtE !== 16'hFFFF || ex_if.ALUSrcE !== 1'b1 || ex_if.RdE !== 4'd2) begin
      n_fail++;
      $display("FAIL addi_imm: got imm=%h alusrc=%b rd=%0d required FFFF 1 2",
               ex_if.ImmExtE, ex_if.ALUSrcE, ex_if.RdE);
    end
    drive_cycle(0, 16'hD800, 16'h0031, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.ImmExtE !== 16'hF800 || ex_if.JumpE !== 1'b1 || ex_if.RegWriteE !== 1'b0) begin
      n_fail++;
      $display("FAIL jmp_imm: got imm=%h jump=%b regw=%b required F800 1 0",
               ex_if.ImmExtE, ex_if.JumpE, ex_if.RegWriteE);
    end
    drive_cycle(0, 16'hE5AB, 16'h0032, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.ImmExtE !== 16'hAB00 || ex_if.Rs1E !== 4'd0 || ex_if.RdE !== 4'd5) begin
      n_fail++;
      $display("FAIL lui_imm: got imm=%h rs1=%0d rd=%0d required AB00 0 5",
               ex_if.ImmExtE, ex_if.Rs1E, ex_if.RdE);
    end
  endtask

  task automatic test_flush();
    drive_cycle(0, 16'hA213, 16'h0040, 1, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.MemWriteE !== 1'b0 || got_vec() !== 87'h0) begin
      n_fail++;
      $display("FAIL flush_bubble: got %h required 0", got_vec());
    end
    drive_cycle(0, 16'hA213, 16'h0040, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.MemWriteE !== 1'b1 || ex_if.ImmExtE !== 16'h0003 || ex_if.RdE !== 4'd0) begin
      n_fail++;
      $display("FAIL flush_release: got memw=%b imm=%h rd=%0d required 1 0003 0",
               ex_if.MemWriteE, ex_if.ImmExtE, ex_if.RdE);
    end
  endtask

  task automatic test_branch();
    drive_cycle(0, 16'hC12E, 16'h0050, 0, 0, 4'd0, 16'h0);
    n_checks++;
    if (ex_if.BranchE !== 1'b1 || ex_if.BranchNeE !== 1'b1 || ex_if.Rs1E !== 4'd1 ||
        ex_if.Rs2E !== 4'd2 || ex_if.ImmExtE !== 16'hFFFE || ex_if.ALUControlE !== 3'b001) begin
      n_fail++;
      $display("FAIL bne: got br=%b bne=%b rs1=%0d rs2=%0d imm=%h alu=%b required 1 1 1 2 FFFE 001",
               ex_if.BranchE, ex_if.BranchNeE, ex_if.Rs1E, ex_if.Rs2E, ex_if.ImmExtE,
               ex_if.ALUControlE);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive_cycle(($urandom_range(0, 49) == 0), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom), 4'($urandom), 16'($urandom));
      n_checks++;
      if (got_rs1d !== 4'(exp_rs1d) || got_rs2d !== 4'(exp_rs2d)) begin
        n_fail++;
        $display("FAIL rand_rsd #%0d instr=%h: got %0d/%0d required %0d/%0d",
                 n, InstrD, got_rs1d, got_rs2d, exp_rs1d, exp_rs2d);
      end
      n_checks++;
      if (got_vec() !== exp_vec) begin
        n_fail++;
        $display("FAIL rand_idex #%0d instr=%h: got %h required %h", n, InstrD, got_vec(), exp_vec);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model_rf[i] = 16'h0;
    test_reset();
    test_wb_bypass();
    test_r0();
    test_immediates();
    test_flush();
    test_branch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
